// File: rtl/i2s_pkg.sv
// Shared FSM state encodings and channel constants for the I2S memory controller.
// Latency: none; this package holds types and constants only.
// Backpressure: none; this package holds types and constants only.
package i2s_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    HOLD  = 3'd2,
    ACK   = 3'd3,
    NEXT  = 3'd4
  } state_t;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

endpackage

// File: rtl/i2s_desc_slots.sv
// Two-entry ping-pong buffer descriptor store with fill/release and slot selection.
// Latency: a write or release becomes visible on the outputs 1 cycle later.
// Backpressure: full is high when both slots are valid; writes are dropped while full.
module i2s_desc_slots #(
  parameter int ADDR_WIDTH = 24,
  parameter int SIZE_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] wr_base,
  input  logic [SIZE_WIDTH-1:0] wr_size,
  input  logic                  release_act,
  output logic                  full,
  output logic                  active,
  output logic                  act_vld,
  output logic [ADDR_WIDTH-1:0] act_base,
  output logic [SIZE_WIDTH-1:0] act_size,
  output logic                  other_vld,
  output logic [ADDR_WIDTH-1:0] other_base
);

  logic [1:0]            vld;
  logic [ADDR_WIDTH-1:0] base [2];
  logic [SIZE_WIDTH-1:0] size [2];

  logic [1:0] vld_rel;
  logic       active_rel;
  logic       wr_ok;
  logic       wr_slot;

  // Apply the release of the finished slot first, then place the write on what remains.
  always_comb begin
    vld_rel    = vld;
    active_rel = active;
    if (release_act) begin
      vld_rel[active] = 1'b0;
      active_rel      = ~active;
    end
    wr_ok = wr && (wr_size != '0) && !(&vld_rel);
    // Playing slot held: fill the other one. Nothing held: slot 0, which becomes active.
    if (vld_rel[active_rel])
      wr_slot = ~active_rel;
    else if (vld_rel == 2'b00)
      wr_slot = 1'b0;
    else
      wr_slot = active_rel;
  end

  // Descriptor registers and the active-slot pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld    <= 2'b00;
      active <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        base[i] <= '0;
        size[i] <= '0;
      end
    end else begin
      vld    <= vld_rel;
      active <= active_rel;
      if (wr_ok) begin
        vld[wr_slot]  <= 1'b1;
        base[wr_slot] <= wr_base;
        size[wr_slot] <= wr_size;
        if (vld_rel == 2'b00)
          active <= 1'b0;
      end
    end
  end

  assign full       = &vld;
  assign act_vld    = vld[active];
  assign act_base   = base[active];
  assign act_size   = size[active];
  assign other_vld  = vld[~active];
  assign other_base = base[~active];

endmodule

// File: rtl/i2s_mem_controller.sv
// Feeds the I2S serializer from memory through two ping-pong descriptors; I2S_MONO_DUP_EN plays each word as L then R.
// Latency: mem_rd_req 1 cycle after a fetch decision; audio_data_ack 1 cycle after request seen in HOLD, falls 1 cycle after it drops.
// Backpressure: one sample held at a time; serializer requests with nothing held set the sticky underrun flag.
module i2s_mem_controller
  import i2s_pkg::*;
#(
  parameter int ADDR_WIDTH = 24,
  parameter int SIZE_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  buf_wr,
  input  logic [ADDR_WIDTH-1:0] buf_base,
  input  logic [SIZE_WIDTH-1:0] buf_size,
  output logic                  buf_full,
  output logic                  buf_done,
  output logic                  active_slot,
  output logic                  underrun,
  output logic                  mem_rd_req,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic                  mem_rd_ack,
  input  logic [31:0]           mem_rd_data,
  input  logic                  audio_data_request,
  output logic                  audio_data_ack,
  output logic [23:0]           audio_data,
  output logic                  audio_lr_bit
);

  state_t                state;
  logic [SIZE_WIDTH-1:0] idx;
  logic [SIZE_WIDTH-1:0] idx_nxt;
  logic                  act_vld;
  logic                  other_vld;
  logic [ADDR_WIDTH-1:0] act_base;
  logic [ADDR_WIDTH-1:0] other_base;
  logic [SIZE_WIDTH-1:0] act_size;
  logic                  release_act;

  assign idx_nxt     = idx + 1'b1;
  assign release_act = (state == NEXT) && (idx == act_size);

  i2s_desc_slots #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .SIZE_WIDTH (SIZE_WIDTH)
  ) u_slots (
    .clk         (clk),
    .rst         (rst),
    .wr          (buf_wr),
    .wr_base     (buf_base),
    .wr_size     (buf_size),
    .release_act (release_act),
    .full        (buf_full),
    .active      (active_slot),
    .act_vld     (act_vld),
    .act_base    (act_base),
    .act_size    (act_size),
    .other_vld   (other_vld),
    .other_base  (other_base)
  );

  // Sequencer: fetch one word, hold it, run the 4-phase serializer handshake, then advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      idx            <= '0;
      mem_rd_req     <= 1'b0;
      mem_rd_addr    <= '0;
      audio_data_ack <= 1'b0;
      audio_data     <= '0;
      audio_lr_bit   <= LEFT;
      buf_done       <= 1'b0;
      underrun       <= 1'b0;
    end else begin
      buf_done <= 1'b0;
      if (audio_data_request && (state == IDLE || state == FETCH))
        underrun <= 1'b1;
      else if (buf_wr)
        underrun <= 1'b0;

      case (state)
        IDLE: begin
          if (enable && act_vld) begin
            state       <= FETCH;
            mem_rd_req  <= 1'b1;
            mem_rd_addr <= act_base + ADDR_WIDTH'(idx);
          end
        end
        FETCH: begin
          if (mem_rd_ack) begin
            mem_rd_req <= 1'b0;
            audio_data <= mem_rd_data[23:0];
`ifdef I2S_MONO_DUP_EN
            audio_lr_bit <= LEFT;
`else
            audio_lr_bit <= idx[0] ? RIGHT : LEFT;
`endif
            state <= HOLD;
          end
        end
        HOLD: begin
          if (enable && audio_data_request) begin
            audio_data_ack <= 1'b1;
            state          <= ACK;
          end
        end
        ACK: begin
          if (!audio_data_request) begin
            audio_data_ack <= 1'b0;
`ifdef I2S_MONO_DUP_EN
            // Left copy done: replay the same word on the right without refetching.
            if (audio_lr_bit == LEFT) begin
              audio_lr_bit <= RIGHT;
              state        <= HOLD;
            end else begin
              idx      <= idx_nxt;
              buf_done <= (idx_nxt == act_size);
              state    <= NEXT;
            end
`else
            idx      <= idx_nxt;
            buf_done <= (idx_nxt == act_size);
            state    <= NEXT;
`endif
          end
        end
        NEXT: begin
          if (idx == act_size) begin
            idx <= '0;
            if (enable && other_vld) begin
              state       <= FETCH;
              mem_rd_req  <= 1'b1;
              mem_rd_addr <= other_base;
            end else begin
              state <= IDLE;
            end
          end else if (enable) begin
            state       <= FETCH;
            mem_rd_req  <= 1'b1;
            mem_rd_addr <= act_base + ADDR_WIDTH'(idx);
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_mem_controller.sv
// Scoreboard bench for i2s_mem_controller: memory responder plus directed serializer steps.
// Latency: expects ack 1 cycle after a request in HOLD and ack low 1 cycle after request drops.
// Backpressure: memory latency is programmable to provoke underrun.
module tb_i2s_mem_controller;

  typedef struct packed {
    logic        last;
    logic        lr;
    logic [23:0] data;
  } samp_t;

`ifdef I2S_MONO_DUP_EN
  localparam int DUP = 2;
`else
  localparam int DUP = 1;
`endif

  logic        clk;
  logic        rst;
  logic        enable;
  logic        buf_wr;
  logic [23:0] buf_base;
  logic [23:0] buf_size;
  logic        buf_full;
  logic        buf_done;
  logic        active_slot;
  logic        underrun;
  logic        mem_rd_req;
  logic [23:0] mem_rd_addr;
  logic        mem_rd_ack;
  logic [31:0] mem_rd_data;
  logic        audio_data_request;
  logic        audio_data_ack;
  logic [23:0] audio_data;
  logic        audio_lr_bit;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int rd_cnt = 0;
  int mem_lat = 1;

  samp_t       exp_q[$];
  logic [23:0] addr_q[$];

  i2s_mem_controller #(.ADDR_WIDTH(24), .SIZE_WIDTH(24)) dut (
    .clk                (clk),
    .rst                (rst),
    .enable             (enable),
    .buf_wr             (buf_wr),
    .buf_base           (buf_base),
    .buf_size           (buf_size),
    .buf_full           (buf_full),
    .buf_done           (buf_done),
    .active_slot        (active_slot),
    .underrun           (underrun),
    .mem_rd_req         (mem_rd_req),
    .mem_rd_addr        (mem_rd_addr),
    .mem_rd_ack         (mem_rd_ack),
    .mem_rd_data        (mem_rd_data),
    .audio_data_request (audio_data_request),
    .audio_data_ack     (audio_data_ack),
    .audio_data         (audio_data),
    .audio_lr_bit       (audio_lr_bit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] mem_word(input logic [23:0] a);
    if (a == 24'h000040) return 24'hAAAAAA;
    if (a == 24'h000041) return 24'h555555;
    return {a[11:0], ~a[11:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Count buf_done pulses.
  always @(negedge clk) if (buf_done === 1'b1) done_cnt++;

  // Memory responder: answers a held request after mem_lat cycles, checking the address.
  initial begin
    logic [23:0] ea;
    mem_rd_ack  = 1'b0;
    mem_rd_data = '0;
    forever begin
      @(negedge clk);
      mem_rd_ack = 1'b0;
      if (mem_rd_req === 1'b1 && rst === 1'b0) begin
        repeat (mem_lat) @(negedge clk);
        if (mem_rd_req === 1'b1 && rst === 1'b0) begin
          ea = (addr_q.size() > 0) ? addr_q.pop_front() : 24'hxxxxxx;
          check("mem_rd_addr", mem_rd_addr, ea);
          mem_rd_data = {8'hEE, mem_word(mem_rd_addr)};
          mem_rd_ack  = 1'b1;
          rd_cnt++;
        end
      end
    end
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1;
    audio_data_request = 1'b0;
    buf_wr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    addr_q.delete();
  endtask

  task automatic load(input logic [23:0] base, input logic [23:0] size, input bit accept);
    samp_t s;
    logic [23:0] a;
    buf_base = base;
    buf_size = size;
    buf_wr   = 1'b1;
    @(negedge clk);
    buf_wr   = 1'b0;
    if (accept) begin
      for (int i = 0; i < int'(size); i++) begin
        a = base + 24'(i);
        addr_q.push_back(a);
        s.data = mem_word(a);
`ifdef I2S_MONO_DUP_EN
        s.last = 1'b0;
        s.lr   = 1'b0;
        exp_q.push_back(s);
        s.last = (i == int'(size) - 1);
        s.lr   = 1'b1;
        exp_q.push_back(s);
`else
        s.last = (i == int'(size) - 1);
        s.lr   = i[0];
        exp_q.push_back(s);
`endif
      end
    end
  endtask

  // One full 4-phase request; chk_lat demands the ack exactly one cycle after the request.
  task automatic serve_one(input bit chk_lat);
    samp_t e;
    int n;
    audio_data_request = 1'b1;
    n = 0;
    while (audio_data_ack !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ack_rise", audio_data_ack, 1'b1);
    if (chk_lat) check("ack_latency", n, 1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    check("audio_data", audio_data, e.data);
    check("audio_lr_bit", audio_lr_bit, e.lr);
    @(negedge clk);
    check("ack_hold", audio_data_ack, 1'b1);
    check("data_hold", audio_data, e.data);
    audio_data_request = 1'b0;
    @(negedge clk);
    check("ack_fall", audio_data_ack, 1'b0);
    check("buf_done_timing", buf_done, e.last);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    int d0;
    int r0;
    rst = 1'b1;
    enable = 1'b0;
    buf_wr = 1'b0;
    buf_base = '0;
    buf_size = '0;
    audio_data_request = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_mem_rd_req", mem_rd_req, 1'b0);
    check("rst_mem_rd_addr", mem_rd_addr, 24'h0);
    check("rst_ack", audio_data_ack, 1'b0);
    check("rst_data", audio_data, 24'h0);
    check("rst_lr", audio_lr_bit, 1'b0);
    check("rst_buf_done", buf_done, 1'b0);
    check("rst_buf_full", buf_full, 1'b0);
    check("rst_active_slot", active_slot, 1'b0);
    check("rst_underrun", underrun, 1'b0);
    rst = 1'b0;

    // Single buffer of four words.
    enable = 1'b1;
    d0 = done_cnt;
    load(24'h100, 24'd4, 1);
    repeat (6) @(negedge clk);
    repeat (4 * DUP) serve_one(1);
    check("t1_active_slot", active_slot, 1'b1);
    check("t1_idle_no_req", mem_rd_req, 1'b0);
    check("t1_reads_left", addr_q.size(), 0);
    check("t1_done_count", done_cnt - d0, 1);
    check("t1_underrun", underrun, 1'b0);

    // Ping-pong switch between two descriptors.
    do_reset();
    d0 = done_cnt;
    load(24'h100, 24'd2, 1);
    load(24'h200, 24'd2, 1);
    check("t2_full", buf_full, 1'b1);
    repeat (6) @(negedge clk);
    repeat (2 * DUP) serve_one(1);
    check("t2_active_switched", active_slot, 1'b1);
    check("t2_not_full", buf_full, 1'b0);
    repeat (2 * DUP) serve_one(1);
    check("t2_underrun", underrun, 1'b0);
    check("t2_done_count", done_cnt - d0, 2);
    check("t2_active_back", active_slot, 1'b0);

    // Slow memory: underrun while fetching, cleared by a later descriptor write.
    do_reset();
    d0 = done_cnt;
    mem_lat = 20;
    load(24'h300, 24'd2, 1);
    audio_data_request = 1'b1;
    repeat (10) @(negedge clk);
    check("t3_no_early_ack", audio_data_ack, 1'b0);
    check("t3_underrun_set", underrun, 1'b1);
    serve_one(0);
    mem_lat = 1;
    repeat (25) @(negedge clk);
    check("t3_underrun_sticky", underrun, 1'b1);
    load(24'h400, 24'd1, 1);
    check("t3_underrun_cleared", underrun, 1'b0);
    repeat (3 * DUP - 1) serve_one(1);
    check("t3_done_count", done_cnt - d0, 2);
    check("t3_underrun_end", underrun, 1'b0);

    // Third write while full is dropped; zero-size write is dropped.
    do_reset();
    d0 = done_cnt;
    enable = 1'b0;
    load(24'h500, 24'd1, 1);
    load(24'h600, 24'd1, 1);
    check("t4_full", buf_full, 1'b1);
    load(24'h700, 24'd3, 0);
    repeat (4) @(negedge clk);
    check("t4_disabled_no_req", mem_rd_req, 1'b0);
    check("t4_still_full", buf_full, 1'b1);
    enable = 1'b1;
    repeat (6) @(negedge clk);
    repeat (2 * DUP) serve_one(1);
    repeat (6) @(negedge clk);
    check("t4_reads_left", addr_q.size(), 0);
    check("t4_done_count", done_cnt - d0, 2);
    check("t4_empty", buf_full, 1'b0);
    r0 = rd_cnt;
    load(24'h800, 24'd0, 0);
    repeat (6) @(negedge clk);
    check("t4_zero_size_no_req", mem_rd_req, 1'b0);
    check("t4_zero_size_no_read", rd_cnt - r0, 0);

    // Reset while the serializer handshake is in ACK.
    do_reset();
    load(24'h900, 24'd4, 1);
    repeat (6) @(negedge clk);
    audio_data_request = 1'b1;
    for (int n = 0; n < 20 && audio_data_ack !== 1'b1; n++) @(negedge clk);
    check("t5_in_ack", audio_data_ack, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("t5_ack_dropped", audio_data_ack, 1'b0);
    check("t5_req_dropped", mem_rd_req, 1'b0);
    check("t5_slots_empty", buf_full, 1'b0);
    check("t5_underrun", underrun, 1'b0);
    rst = 1'b0;
    audio_data_request = 1'b0;
    exp_q.delete();
    addr_q.delete();
    repeat (4) @(negedge clk);
    check("t5_no_fetch_after", mem_rd_req, 1'b0);

    // Two-word buffer at 0x40 (mono build plays each word L then R).
    do_reset();
    r0 = rd_cnt;
    load(24'h040, 24'd2, 1);
    repeat (6) @(negedge clk);
    repeat (2 * DUP) serve_one(1);
    check("t6_read_count", rd_cnt - r0, 2);

    // Odd-length buffer followed by another: second buffer restarts on left.
    do_reset();
    d0 = done_cnt;
    load(24'h060, 24'd3, 1);
    load(24'h070, 24'd2, 1);
    repeat (6) @(negedge clk);
    repeat (5 * DUP) serve_one(1);
    check("t7_done_count", done_cnt - d0, 2);
    check("t7_samples_left", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
